// File: rtl/spg_pkg.sv
// Shared types and constants for the serial pattern generator.
package spg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 4;

  // PRBS7, polynomial x^7 + x^6 + 1
  localparam logic [6:0] PRBS_SEED  = 7'h7F;
  localparam int         PRBS_TAP_A = 6;
  localparam int         PRBS_TAP_B = 5;

  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
  endfunction

endpackage

// File: rtl/serial_pattern_gen_bit_tick.sv
// Free-running DIV-cycle divider with synchronous clear; o_tick marks the last cycle of each period.
module bit_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_clr || (r_cnt == LAST))
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/serial_pattern_gen.sv
// MSB-first serial pattern transmitter with repeat count and start/busy/done handshake.
// Optional macro SPG_PRBS_EN: PRBS7 idle stream on x.
module serial_pattern_gen
  import spg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] repeat_n,
  output logic             x,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = $clog2(WIDTH);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shadow, r_shift, w_shift_nxt;
  logic [BIT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [REP_W-1:0] r_rep, w_rep_nxt;
  logic             w_tick, w_accept, w_idle_x;
  logic             r_x, r_bit_valid, r_busy, r_done;

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_accept),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_rep_nxt     = r_rep;
    w_accept      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept      = 1'b1;
          w_shift_nxt   = pattern;
          w_rep_nxt     = repeat_n;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_tick) begin
          if (r_bit_cnt == BIT_W'(WIDTH - 1)) begin
            // Reload on the final tick so repetitions follow with no gap
            if (r_rep != '0) begin
              w_rep_nxt     = r_rep - REP_W'(1);
              w_shift_nxt   = r_shadow;
              w_bit_cnt_nxt = '0;
            end else begin
              w_state_nxt   = ST_DONE;
            end
          end else begin
            w_shift_nxt   = {r_shift[WIDTH-2:0], 1'b0};
            w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
          end
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef SPG_PRBS_EN
  logic [6:0] r_lfsr, w_lfsr_nxt;

  // LFSR only advances while idle, so it resumes where it left off after a transmission
  assign w_lfsr_nxt = ((r_state == ST_IDLE) && w_tick) ? prbs7_step(r_lfsr) : r_lfsr;
  assign w_idle_x   = w_lfsr_nxt[6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lfsr <= PRBS_SEED;
    else     r_lfsr <= w_lfsr_nxt;
  end
`else
  assign w_idle_x = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shadow  <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_rep     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_rep     <= w_rep_nxt;
      if (w_accept) r_shadow <= pattern;
    end
  end

  // Outputs registered from next-state values so x is glitch-free and aligned with state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x         <= 1'b0;
      r_bit_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_bit_valid <= (w_state_nxt == ST_SHIFT);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= (w_state_nxt == ST_DONE);
      case (w_state_nxt)
        ST_SHIFT: r_x <= w_shift_nxt[WIDTH-1];
        ST_IDLE:  r_x <= w_idle_x;
        default:  r_x <= 1'b0;
      endcase
    end
  end

  assign x         = r_x;
  assign bit_valid = r_bit_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen: vector table, corner sequences, randomized model check.
module tb_serial_pattern_gen;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  pattern;
  logic [RW-1:0] repeat_n;
  logic          x, bit_valid, busy, done;

  logic          start1;
  logic [W-1:0]  pat1;
  logic [RW-1:0] rep1;
  logic          x1, bv1, busy1, done1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_pattern_gen #(.WIDTH(W), .DIV(D), .REP_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .repeat_n(repeat_n),
    .x(x), .bit_valid(bit_valid), .busy(busy), .done(done)
  );

  serial_pattern_gen #(.WIDTH(W), .DIV(1), .REP_W(RW)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pattern(pat1), .repeat_n(rep1),
    .x(x1), .bit_valid(bv1), .busy(busy1), .done(done1)
  );

`ifdef SPG_PRBS_EN
  logic          start2;
  logic [W-1:0]  pat2;
  logic [RW-1:0] rep2;
  logic          x2, bv2, busy2, done2;

  serial_pattern_gen #(.WIDTH(W), .DIV(2), .REP_W(RW)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .pattern(pat2), .repeat_n(rep2),
    .x(x2), .bit_valid(bv2), .busy(busy2), .done(done2)
  );
`endif

  typedef struct {
    logic [W-1:0]  pat;
    logic [RW-1:0] rep;
    int            inj_at;
    logic [W-1:0]  inj_pat;
    int            exp_total;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {x, bit_valid, busy, done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one transmission and checks every cycle of it, plus DONE and the idle cycle after.
  task automatic send_and_check(input logic [W-1:0] pat, input logic [RW-1:0] rep,
                                input int inj_at, input logic [W-1:0] inj_pat,
                                input int exp_total, input string tag);
    int bad;
    logic [3:0] e;
    bad = 0;
    pattern = pat; repeat_n = rep; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < exp_total; t++) begin
      e = {pat[W-1-((t/D)%W)], 3'b110};
      if (outs() !== e) bad++;
      if (t == inj_at) begin
        start = 1'b1; pattern = inj_pat; repeat_n = '1;
      end else if (t == inj_at + D) begin
        start = 1'b0; pattern = pat;
      end
      tick();
    end
    check({tag, "_stream_bad"}, bad, 0);
    check({tag, "_done_cycle"}, outs(), 4'b0011);
    tick();
    check({tag, "_idle_after"}, outs(), 4'b0000);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     m_t, m_total, ndone, bad;
    logic [W-1:0]  m_pat, p;
    logic [RW-1:0] r;
    logic   s;
    logic [3:0] e;

    rst = 1'b1; start = 1'b0; pattern = '0; repeat_n = '0;
    start1 = 1'b0; pat1 = '0; rep1 = '0;
`ifdef SPG_PRBS_EN
    start2 = 1'b0; pat2 = '0; rep2 = '0;
`endif
    #12;
    check("reset_outs", outs(), 4'b0000);
    check("reset_outs_div1", {x1, bv1, busy1, done1}, 4'b0000);
    tick();
    rst = 1'b0;

`ifdef SPG_PRBS_EN
    begin
      int o[0:400];
      for (int k = 0; k < 7; k++) o[k] = 1;
      for (int k = 7; k <= 400; k++) o[k] = o[k-7] ^ o[k-6];
      bad = 0;
      for (int n = 1; n <= 300; n++) begin
        tick();
        if ({x2, bv2, busy2} !== {o[n/2][0], 2'b00}) bad++;
      end
      check("prbs_stream_bad", bad, 0);
      check("prbs_period", o[127 + 5], o[5]);
      pat2 = 8'hC3; start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int t = 0; t < 6; t++) begin
        check("prbs_start_align", {x2, bv2}, {pat2[W-1-(t/2)], 1'b1});
        tick();
      end
    end
`endif

    tbl[0] = '{8'b1101_0110, 4'd0,  -1, 8'h00, 32};
    tbl[1] = '{8'hA5,        4'd2,  -1, 8'h00, 96};
    tbl[2] = '{8'h0F,        4'd0,   8, 8'hF0, 32};
    tbl[3] = '{8'hFF,        4'd15, -1, 8'h00, 512};
    tbl[4] = '{8'h80,        4'd1,  -1, 8'h00, 64};
    tbl[5] = '{8'h01,        4'd0,  20, 8'hAA, 32};
    for (int i = 0; i < 6; i++)
      send_and_check(tbl[i].pat, tbl[i].rep, tbl[i].inj_at, tbl[i].inj_pat,
                     tbl[i].exp_total, $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of bit 3
    pattern = 8'h3C; repeat_n = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 13; t++) tick();
    check("pre_rst_outs", outs(), 4'b1110);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outs", outs(), 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (done || busy) ndone++;
    end
    check("no_done_after_abort", ndone, 0);
    send_and_check(8'h96, 4'd0, -1, 8'h00, 32, "post_rst");

    // DIV=1: one bit per clock
    pat1 = 8'h81; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int t = 0; t < 8; t++) begin
      check($sformatf("div1_bit%0d", t), {x1, bv1, busy1, done1}, {pat1[W-1-t], 3'b110});
      tick();
    end
    check("div1_done", {x1, bv1, busy1, done1}, 4'b0011);
    tick();
    check("div1_idle", {x1, bv1, busy1, done1}, 4'b0000);

    // Randomized stimulus against a transaction-level model
    m_t = -1; m_total = 0; m_pat = '0; bad = 0;
    for (int c = 0; c < 4000; c++) begin
      s = ($urandom_range(0, 3) == 0);
      p = W'($urandom);
      r = ($urandom_range(0, 7) == 0) ? 4'd15 : RW'($urandom_range(0, 2));
      start = s; pattern = p; repeat_n = r;
      @(posedge clk);
      if (m_t < 0) begin
        if (s) begin
          m_pat = p; m_total = W * D * (int'(r) + 1); m_t = 0;
        end
      end else begin
        m_t++;
        if (m_t > m_total) m_t = -1;
      end
      #1;
      if (m_t < 0)            e = 4'b0000;
      else if (m_t < m_total) e = {m_pat[W-1-((m_t/D)%W)], 3'b110};
      else                    e = 4'b0011;
      check("random_cycle", outs(), e);
    end
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
